// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int          HDR_BYTES      = 2;
  localparam int          BYTES_PER_WORD = 4;
  localparam logic [7:0]  CSUM_GOOD      = 8'h00;

  // Byte address of a word index: {index, 2'b00}, zero-extended to 32 bits.
  function automatic logic [31:0] word_addr(input logic [15:0] idx);
    return {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Little-endian 4-byte assembler: the first byte of a word lands in bits [7:0].
// Emits a registered one-cycle word_valid_o with the completed word.
module loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_q;
  logic        word_valid_q;
  logic [31:0] word_q;
  logic [7:0]  lane_w [3];

  assign last_byte_o  = (cnt_q == LAST_LANE);
  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

  // Byte position within the current word; wraps naturally after lane 3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 2'd0;
    end else if (clr_i) begin
      cnt_q <= 2'd0;
    end else if (byte_en_i) begin
      cnt_q <= cnt_q + 2'd1;
    end
  end

  // Lanes 0..2 are buffered; lane 3 is taken straight from the input when the word closes.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [7:0] lane_q;

    // Capture the byte destined for this lane.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lane_q <= 8'h00;
      end else if (byte_en_i && !clr_i && (cnt_q == 2'(gi))) begin
        lane_q <= byte_i;
      end
    end

    assign lane_w[gi] = lane_q;
  end

  // Publish the completed word for exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_valid_q <= 1'b0;
      word_q       <= 32'h0;
    end else if (clr_i) begin
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= byte_en_i && last_byte_o;
      if (byte_en_i && last_byte_o) begin
        word_q <= {byte_i, lane_w[2], lane_w[1], lane_w[0]};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a framed byte stream (length, payload, checksum),
// writes payload words to instruction memory and holds the core in reset
// until a frame with a good checksum has been loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] WORDS_W = 17'(WORDS);

  state_e      state_q;
  logic [7:0]  len_lo_q;
  logic [15:0] len_q;
  logic [15:0] idx_q;
  logic [7:0]  sum_q;
  logic [31:0] addr_q;
  logic        byte_ready_q;
  logic        core_reset_q;
  logic        done_q;
  logic        error_q;

  logic        xfer;
  logic        frame_start;
  logic [15:0] len_d;
  logic [7:0]  sum_d;
  logic        pk_last;
  logic        pk_valid;
  logic [31:0] pk_word;

  assign xfer        = byte_valid && byte_ready_q;
  assign frame_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign len_d       = {byte_data, len_lo_q};
  assign sum_d       = sum_q + byte_data;

  loader_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (frame_start),
    .byte_en_i    (xfer && (state_q == ST_DATA)),
    .byte_i       (byte_data),
    .last_byte_o  (pk_last),
    .word_valid_o (pk_valid),
    .word_o       (pk_word)
  );

  assign byte_ready = byte_ready_q;
  assign imem_we    = pk_valid;
  assign imem_wd    = pk_word;
  assign imem_addr  = addr_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign error      = error_q;

  // Frame parser FSM with registered handshake, address and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_lo_q     <= 8'h00;
      len_q        <= 16'h0;
      idx_q        <= 16'h0;
      sum_q        <= 8'h00;
      addr_q       <= 32'h0;
      byte_ready_q <= 1'b0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_q      <= ST_HDR0;
            idx_q        <= 16'h0;
            sum_q        <= 8'h00;
            byte_ready_q <= 1'b1;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
          end
        end
        ST_HDR0: begin
          if (xfer) begin
            len_lo_q <= byte_data;
            sum_q    <= sum_d;
            state_q  <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (xfer) begin
            sum_q <= sum_d;
            len_q <= len_d;
            if ({1'b0, len_d} > WORDS_W) begin
              state_q      <= ST_ERR;
              byte_ready_q <= 1'b0;
              error_q      <= 1'b1;
            end else if (len_d == 16'h0) begin
              state_q <= ST_CSUM;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            sum_q <= sum_d;
            if (pk_last) begin
              // Address is registered alongside the packer's word so both appear with the strobe.
              addr_q <= word_addr(idx_q);
              idx_q  <= idx_q + 16'd1;
              if (idx_q == (len_q - 16'd1)) begin
                state_q <= ST_CSUM;
              end
            end
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            sum_q        <= sum_d;
            byte_ready_q <= 1'b0;
            if (sum_d == CSUM_GOOD) begin
              state_q      <= ST_DONE;
              done_q       <= 1'b1;
              core_reset_q <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              error_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          byte_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-cycle vector table plus hand-written
// sequences for asynchronous reset and the maximum-length frame.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        core_reset;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  // Flag bits: {byte_ready, imem_we, core_reset, done, error}
  localparam logic [4:0] R = 5'b10000;
  localparam logic [4:0] W = 5'b01000;
  localparam logic [4:0] C = 5'b00100;
  localparam logic [4:0] D = 5'b00010;
  localparam logic [4:0] E = 5'b00001;

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic [4:0]  exp_flags;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[$];

  imem_loader #(.WORDS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wd    (imem_wd),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] flags();
    return {byte_ready, imem_we, core_reset, done, error};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic v, input logic [7:0] d,
                     input logic [4:0] f, input logic [31:0] a, input logic [31:0] w);
    vec_t t;
    t.start = s; t.valid = v; t.data = d;
    t.exp_flags = f; t.exp_addr = a; t.exp_wd = w;
    vecs.push_back(t);
  endtask

  // One 2-word frame; trailer cs makes the byte sum 0x00 when cs = 0xD7.
  task automatic add_frame(input logic [7:0] cs, input logic [4:0] end_flags);
    add(0, 1, 8'h02, R|C, 0, 0);
    add(0, 1, 8'h00, R|C, 0, 0);
    add(0, 1, 8'h13, R|C, 0, 0);
    add(1, 1, 8'h05, R|C, 0, 0);          // start ignored in DATA
    add(0, 1, 8'hA0, R|C, 0, 0);
    add(0, 1, 8'h00, R|W|C, 32'h0, 32'h00A00513);
    add(0, 1, 8'h6F, R|C, 0, 0);
    add(0, 0, 8'h55, R|C, 0, 0);          // stall, byte ignored
    add(0, 1, 8'h00, R|C, 0, 0);
    add(0, 1, 8'h00, R|C, 0, 0);
    add(0, 1, 8'h00, R|W|C, 32'h4, 32'h0000006F);
    add(0, 1, cs,    end_flags, 0, 0);
    add(0, 1, 8'h33, end_flags, 0, 0);    // no transfer once finished
  endtask

  initial begin
    logic [7:0] sum;
    int         writes;
    logic [7:0] b;
    logic [31:0] exp_word;

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", 64'(flags()), 64'(C));
    chk("reset_addr",  64'(imem_addr), 64'h0);
    chk("reset_wd",    64'(imem_wd), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // ---- vector table ----
    add(1, 0, 8'h00, R|C, 0, 0);           // IDLE -> HDR0
    add_frame(8'hD7, D);                   // good checksum
    add(1, 0, 8'h00, R|C, 0, 0);           // DONE -> HDR0 clears done, reasserts core_reset
    add_frame(8'hD8, C|E);                 // bad checksum, words still written
    add(1, 0, 8'h00, R|C, 0, 0);           // ERR -> HDR0 clears error
    add(0, 1, 8'h41, R|C, 0, 0);           // N = 65
    add(0, 1, 8'h00, C|E, 0, 0);           // oversize -> ERR
    add(0, 1, 8'h12, C|E, 0, 0);
    add(1, 0, 8'h00, R|C, 0, 0);           // zero-length frame
    add(0, 1, 8'h00, R|C, 0, 0);
    add(0, 0, 8'h00, R|C, 0, 0);
    add(0, 1, 8'h00, R|C, 0, 0);           // HDR1 -> CSUM
    add(0, 0, 8'hFF, R|C, 0, 0);
    add(0, 1, 8'h00, D, 0, 0);             // good checksum, no writes
    add(1, 0, 8'h00, R|C, 0, 0);           // restart from DONE

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start = vecs[i].start; byte_valid = vecs[i].valid; byte_data = vecs[i].data;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_flags", i), 64'(flags()), 64'(vecs[i].exp_flags));
      if (vecs[i].exp_flags[3]) begin
        chk($sformatf("vec%0d_addr", i), 64'(imem_addr), 64'(vecs[i].exp_addr));
        chk($sformatf("vec%0d_wd", i),   64'(imem_wd),   64'(vecs[i].exp_wd));
      end
    end

    // ---- reset mid-DATA (loader is in HDR0) ----
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0; byte_valid = 1'b1;
      b = (i == 0) ? 8'h02 : (i == 1) ? 8'h00 : 8'(8'h0F + i);
      byte_data = b;
      @(posedge clk);
      #1;
      chk($sformatf("mid_we%0d", i), 64'(imem_we), 64'(i == 5));
    end
    #2 reset = 1'b1;
    #1;
    chk("async_reset_flags", 64'(flags()), 64'(C));
    chk("async_reset_addr",  64'(imem_addr), 64'h0);
    chk("async_reset_wd",    64'(imem_wd), 64'h0);
    @(negedge clk);
    start = 1'b1;                          // start with reset held: reset wins
    @(posedge clk);
    #1;
    chk("start_vs_reset", 64'(flags()), 64'(C));
    @(negedge clk);
    reset = 1'b0; start = 1'b0; byte_valid = 1'b1; byte_data = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_reset_idle%0d", i), 64'(flags()), 64'(C));
    end

    // ---- maximum length frame: N = 64 = WORDS ----
    @(negedge clk);
    start = 1'b1; byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    sum = 8'h00;
    writes = 0;
    for (int i = 0; i < 2 + 256; i++) begin
      b = (i == 0) ? 8'h40 : (i == 1) ? 8'h00 : 8'(i - 2);
      byte_valid = 1'b1; byte_data = b;
      sum = sum + b;
      @(posedge clk);
      #1;
      if (i >= 5 && ((i - 2) % 4) == 3) begin
        exp_word = {8'(i - 2), 8'(i - 3), 8'(i - 4), 8'(i - 5)};
        chk($sformatf("max_we%0d", writes),   64'(imem_we), 64'h1);
        chk($sformatf("max_addr%0d", writes), 64'(imem_addr), 64'(writes * 4));
        chk($sformatf("max_wd%0d", writes),   64'(imem_wd), 64'(exp_word));
        writes++;
      end else if (imem_we) begin
        chk($sformatf("max_spurious_we%0d", i), 64'(imem_we), 64'h0);
      end
      @(negedge clk);
    end
    byte_data = 8'(8'h00 - sum);
    @(posedge clk);
    #1;
    chk("max_flags", 64'(flags()), 64'(D));
    chk("max_writes", 64'(writes), 64'd64);
    @(negedge clk);
    byte_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
